ntps_rst_seq: RTL and testbench

- Parametrised reset sequencer for the NTP server top level.
- Replaces the fixed single-domain processor-system reset with N peripheral channels.
- Releases resets in a staged, ordered sequence: bus/interconnect first, then peripherals one by one in index order, MicroBlaze last.
- Filters the aux reset, re-enters reset on loss of DCM lock, and reports sequence completion and a saturating reset-event count.

---
 rtl/ntps_rst_pkg.sv | 27 ++
 rtl/ntps_rst_sync.sv | 31 +++
 rtl/ntps_rst_seq.sv | 178 +++++++++++++++++
 tb/tb_ntps_rst_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ntps_rst_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ntps_rst_pkg : shared types, constants and sizing helper for ntps_rst_seq
// Rev 1.0
// ----------------------------------------------------------------------------
package ntps_rst_pkg;

  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    REL_PERIPH = 2'd1,
    REL_MB     = 2'd2,
    RUN        = 2'd3
  } state_e;

  localparam int RST_COUNT_W = 8;

  // Wide enough to hold the largest of the three timing parameters itself.
  function automatic int cnt_width(input int hold, input int gap, input int filt);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (filt > m) m = filt;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntps_rst_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ntps_rst_sync : 2-FF synchroniser with parametrised reset value
// Rev 1.0
// ----------------------------------------------------------------------------
module ntps_rst_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/ntps_rst_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ntps_rst_seq : staged reset sequencer (bus, peripherals in order, MicroBlaze)
// Optional per-channel software reset pulses with NTPS_RST_SWRST_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module ntps_rst_seq
  import ntps_rst_pkg::*;
#(
  parameter int   NUM_PERIPH    = 2,
  parameter int   HOLD_CYCLES   = 16,
  parameter int   STAGE_GAP     = 4,
  parameter int   FILTER_CYCLES = 4,
  parameter logic AUX_RST_POL   = 1'b1
) (
  input  logic                   slowest_sync_clk,
  input  logic                   ext_reset_in,
  input  logic                   aux_reset_in,
  input  logic                   mb_debug_sys_rst,
  input  logic                   dcm_locked,
`ifdef NTPS_RST_SWRST_EN
  input  logic [NUM_PERIPH-1:0]  sw_rst_req,
`endif
  output logic                   mb_reset,
  output logic                   bus_struct_reset,
  output logic [NUM_PERIPH-1:0]  peripheral_reset,
  output logic                   interconnect_aresetn,
  output logic [NUM_PERIPH-1:0]  peripheral_aresetn,
  output logic                   reset_done,
  output logic [RST_COUNT_W-1:0] reset_count
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, FILTER_CYCLES);
  localparam int IW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_PERIPH - 1);

  logic rst_int_n;
  logic aux_s;
  logic dbg_s;
  logic lock_s;

  ntps_rst_sync #(.RST_VAL(1'b0)) u_sync_rst (
    .clk_i(slowest_sync_clk), .rst_ni(ext_reset_in), .d_i(1'b1), .q_o(rst_int_n));
  ntps_rst_sync #(.RST_VAL(~AUX_RST_POL)) u_sync_aux (
    .clk_i(slowest_sync_clk), .rst_ni(ext_reset_in), .d_i(aux_reset_in), .q_o(aux_s));
  ntps_rst_sync #(.RST_VAL(1'b0)) u_sync_dbg (
    .clk_i(slowest_sync_clk), .rst_ni(ext_reset_in), .d_i(mb_debug_sys_rst), .q_o(dbg_s));
  ntps_rst_sync #(.RST_VAL(1'b0)) u_sync_lock (
    .clk_i(slowest_sync_clk), .rst_ni(ext_reset_in), .d_i(dcm_locked), .q_o(lock_s));

  logic          aux_act;
  logic          aux_trig;
  logic          trig;
  logic [CW-1:0] filt_q;

  assign aux_act  = (aux_s == AUX_RST_POL);
  assign aux_trig = aux_act && (filt_q == FILT_LAST);
  assign trig     = aux_trig | dbg_s | ~lock_s;

  // Counts consecutive active cycles, saturating at the trigger threshold.
  always_ff @(posedge slowest_sync_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      filt_q <= '0;
    end else if (!aux_act) begin
      filt_q <= '0;
    end else if (filt_q != FILT_LAST) begin
      filt_q <= filt_q + 1'b1;
    end
  end

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic                   mb_q;
  logic                   bus_q;
  logic [NUM_PERIPH-1:0]  per_q;
  logic                   done_q;
  logic [RST_COUNT_W-1:0] evt_q;
`ifdef NTPS_RST_SWRST_EN
  localparam logic [CW-1:0] SW_START = CW'(STAGE_GAP);
  logic [NUM_PERIPH-1:0]  req_prev_q;
  logic [CW-1:0]          sw_cnt_q [NUM_PERIPH];
`endif

  always_ff @(posedge slowest_sync_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      mb_q    <= 1'b1;
      bus_q   <= 1'b1;
      per_q   <= '1;
      done_q  <= 1'b0;
      evt_q   <= '0;
`ifdef NTPS_RST_SWRST_EN
      req_prev_q <= '0;
      for (int i = 0; i < NUM_PERIPH; i++) sw_cnt_q[i] <= '0;
`endif
    end else begin
`ifdef NTPS_RST_SWRST_EN
      req_prev_q <= sw_rst_req;
`endif
      // A trigger overrides any release due on the same edge.
      if (trig) begin
        state_q <= HOLD;
        cnt_q   <= '0;
        idx_q   <= '0;
        mb_q    <= 1'b1;
        bus_q   <= 1'b1;
        per_q   <= '1;
        done_q  <= 1'b0;
        if (state_q == RUN && evt_q != '1) evt_q <= evt_q + 1'b1;
`ifdef NTPS_RST_SWRST_EN
        for (int i = 0; i < NUM_PERIPH; i++) sw_cnt_q[i] <= '0;
`endif
      end else begin
        case (state_q)
          HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              bus_q   <= 1'b0;
              state_q <= REL_PERIPH;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          REL_PERIPH: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q        <= '0;
              per_q[idx_q] <= 1'b0;
              if (idx_q == IDX_LAST) state_q <= REL_MB;
              else                   idx_q   <= idx_q + 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          REL_MB: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q   <= '0;
              mb_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RUN: begin
`ifdef NTPS_RST_SWRST_EN
            for (int i = 0; i < NUM_PERIPH; i++) begin
              if (sw_rst_req[i] && !req_prev_q[i]) begin
                per_q[i]    <= 1'b1;
                sw_cnt_q[i] <= SW_START;
              end else if (sw_cnt_q[i] != '0) begin
                sw_cnt_q[i] <= sw_cnt_q[i] - 1'b1;
                if (sw_cnt_q[i] == CW'(1)) per_q[i] <= 1'b0;
              end
            end
`endif
          end
          default: state_q <= HOLD;
        endcase
      end
    end
  end

  assign mb_reset             = mb_q;
  assign bus_struct_reset     = bus_q;
  assign peripheral_reset     = per_q;
  assign interconnect_aresetn = ~bus_q;
  assign peripheral_aresetn   = ~per_q;
  assign reset_done           = done_q;
  assign reset_count          = evt_q;

endmodule
`default_nettype wire

// File: tb/tb_ntps_rst_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ntps_rst_seq : directed self-checking bench for ntps_rst_seq (defaults)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ntps_rst_seq;

  logic       clk = 1'b0;
  logic       ext_reset_in;
  logic       aux_reset_in;
  logic       mb_debug_sys_rst;
  logic       dcm_locked;
  logic       mb_reset;
  logic       bus_struct_reset;
  logic [1:0] peripheral_reset;
  logic       interconnect_aresetn;
  logic [1:0] peripheral_aresetn;
  logic       reset_done;
  logic [7:0] reset_count;
`ifdef NTPS_RST_SWRST_EN
  logic [1:0] sw_rst_req;
`endif

  int checks = 0;
  int errors = 0;
  int n;
  int timeouts;

  always #5 clk = ~clk;

  ntps_rst_seq dut (
    .slowest_sync_clk    (clk),
    .ext_reset_in        (ext_reset_in),
    .aux_reset_in        (aux_reset_in),
    .mb_debug_sys_rst    (mb_debug_sys_rst),
    .dcm_locked          (dcm_locked),
`ifdef NTPS_RST_SWRST_EN
    .sw_rst_req          (sw_rst_req),
`endif
    .mb_reset            (mb_reset),
    .bus_struct_reset    (bus_struct_reset),
    .peripheral_reset    (peripheral_reset),
    .interconnect_aresetn(interconnect_aresetn),
    .peripheral_aresetn  (peripheral_aresetn),
    .reset_done          (reset_done),
    .reset_count         (reset_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cyc);
    repeat (cyc) @(negedge clk);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (reset_done !== 1'b1 && cyc < 100) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic dbg_pulse;
    mb_debug_sys_rst = 1'b1;
    step(1);
    mb_debug_sys_rst = 1'b0;
  endtask

  initial begin
    ext_reset_in     = 1'b0;
    aux_reset_in     = 1'b0;
    mb_debug_sys_rst = 1'b0;
    dcm_locked       = 1'b1;
`ifdef NTPS_RST_SWRST_EN
    sw_rst_req       = 2'b00;
`endif
    step(5);
    chk("rst_mb",    mb_reset, 1);
    chk("rst_bus",   bus_struct_reset, 1);
    chk("rst_per",   peripheral_reset, 2'b11);
    chk("rst_ic_n",  interconnect_aresetn, 0);
    chk("rst_per_n", peripheral_aresetn, 2'b00);
    chk("rst_done",  reset_done, 0);
    chk("rst_count", reset_count, 0);

    // Release: edge numbering starts at the first posedge after the rise.
    ext_reset_in = 1'b1;
    step(17);
    chk("e17_bus",  bus_struct_reset, 1);
    step(1);
    chk("e18_bus",  bus_struct_reset, 0);
    chk("e18_ic_n", interconnect_aresetn, 1);
    chk("e18_per",  peripheral_reset, 2'b11);
    step(3);
    chk("e21_per",  peripheral_reset, 2'b11);
    step(1);
    chk("e22_per",  peripheral_reset, 2'b10);
    chk("e22_pern", peripheral_aresetn, 2'b01);
    step(4);
    chk("e26_per",  peripheral_reset, 2'b00);
    step(3);
    chk("e29_mb",   mb_reset, 1);
    chk("e29_done", reset_done, 0);
    step(1);
    chk("e30_mb",   mb_reset, 0);
    chk("e30_done", reset_done, 1);
    chk("e30_cnt",  reset_count, 0);

    // Aux pulse shorter than the filter is ignored.
    aux_reset_in = 1'b1;
    step(3);
    aux_reset_in = 1'b0;
    step(6);
    chk("aux3_done", reset_done, 1);
    chk("aux3_per",  peripheral_reset, 2'b00);
    chk("aux3_cnt",  reset_count, 0);

    // Four-cycle aux pulse triggers two sync edges plus three filter edges later.
    aux_reset_in = 1'b1;
    step(4);
    aux_reset_in = 1'b0;
    step(1);
    chk("aux4_pre_done", reset_done, 1);
    step(1);
    chk("aux4_done", reset_done, 0);
    chk("aux4_mb",   mb_reset, 1);
    chk("aux4_bus",  bus_struct_reset, 1);
    chk("aux4_per",  peripheral_reset, 2'b11);
    chk("aux4_cnt",  reset_count, 1);
    wait_done(n);
    chk("aux4_seq_len", n, 28);

    // Debug reset, then lock loss right after channel 0 is released.
    dbg_pulse();
    step(2);
    chk("dbg_done", reset_done, 0);
    chk("dbg_cnt",  reset_count, 2);
    step(20);
    chk("lk_ch0",   peripheral_reset, 2'b10);
    dcm_locked = 1'b0;
    step(1);
    dcm_locked = 1'b1;
    step(1);
    chk("lk_pre_per", peripheral_reset, 2'b10);
    step(1);
    chk("lk_per",   peripheral_reset, 2'b11);
    chk("lk_bus",   bus_struct_reset, 1);
    chk("lk_done",  reset_done, 0);
    chk("lk_cnt",   reset_count, 2);
    wait_done(n);
    chk("lk_seq_len", n, 28);

    // External reset asserted while in REL_MB acts before the next edge.
    dbg_pulse();
    step(2);
    chk("mb_cnt", reset_count, 3);
    step(25);
    chk("relmb_mb",  mb_reset, 1);
    chk("relmb_per", peripheral_reset, 2'b00);
    ext_reset_in = 1'b0;
    #1;
    chk("async_mb",   mb_reset, 1);
    chk("async_bus",  bus_struct_reset, 1);
    chk("async_per",  peripheral_reset, 2'b11);
    chk("async_ic_n", interconnect_aresetn, 0);
    chk("async_pern", peripheral_aresetn, 2'b00);
    chk("async_cnt",  reset_count, 0);
    @(negedge clk);
    ext_reset_in = 1'b1;
    wait_done(n);
    chk("ext_seq_len", n, 30);

    // Saturation of the event counter.
    timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      dbg_pulse();
      step(2);
      wait_done(n);
      if (n >= 100) timeouts++;
      if (i == 254) chk("sat_255", reset_count, 255);
    end
    chk("sat_timeouts", timeouts, 0);
    chk("sat_256", reset_count, 255);

`ifdef NTPS_RST_SWRST_EN
    sw_rst_req = 2'b10;
    step(1);
    sw_rst_req = 2'b00;
    chk("sw_per1",  peripheral_reset, 2'b10);
    chk("sw_pern1", peripheral_aresetn, 2'b01);
    chk("sw_mb",    mb_reset, 0);
    chk("sw_done",  reset_done, 1);
    step(3);
    chk("sw_per4",  peripheral_reset, 2'b10);
    step(1);
    chk("sw_per5",  peripheral_reset, 2'b00);
    chk("sw_cnt",   reset_count, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
